// File: rtl/key_debouncer.sv
// Push-button conditioner: two-flop synchronizer, stable-time debounce FSM, level plus strobes.
// Define KEY_ACTIVE_LOW_EN to invert key_raw ahead of the synchronizer for pulled-up keys.
module key_debouncer #(
    parameter int unsigned STABLE_CYCLES = 500,
    parameter int unsigned CNT_W         = 26
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    typedef enum logic [1:0] {
        StIdleLow,
        StWaitHigh,
        StIdleHigh,
        StWaitLow
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             key_in;
    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d, press_d, release_d;

`ifdef KEY_ACTIVE_LOW_EN
    assign key_in = ~key_raw;
`else
    assign key_in = key_raw;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= key_in;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= StIdleLow;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
        end
    end

    // Counter only advances while below CntMax, so it can never exceed it or wrap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = key_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            StIdleLow: begin
                if (s2_q) begin
                    state_d = StWaitHigh;
                    cnt_d   = CntOne;
                end
            end
            StWaitHigh: begin
                if (!s2_q) begin
                    state_d = StIdleLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdleHigh;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StIdleHigh: begin
                if (!s2_q) begin
                    state_d = StWaitLow;
                    cnt_d   = CntOne;
                end
            end
            StWaitLow: begin
                if (s2_q) begin
                    state_d = StIdleHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d   = StIdleLow;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdleLow;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer: STABLE_CYCLES=8 instance plus a STABLE_CYCLES=1 instance.
// Stimulus is written in "pressed" terms and inverted onto key_raw when KEY_ACTIVE_LOW_EN is set.
module tb_key_debouncer;

`ifdef KEY_ACTIVE_LOW_EN
    localparam bit ActLow = 1'b1;
`else
    localparam bit ActLow = 1'b0;
`endif

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    logic key_raw  = ActLow;
    logic key_raw1 = ActLow;
    logic key_level, key_press, key_release;
    logic key_level1, key_press1, key_release1;

    int checks = 0;
    int errors = 0;
    int press_cnt = 0, release_cnt = 0, press_cnt1 = 0, release_cnt1 = 0;
    int viol = 0;
    bit prev_strobe = 1'b0, prev_strobe1 = 1'b0;
    int base_p, base_r, base_p1;

    always #10 CLOCK_50 = ~CLOCK_50;

    key_debouncer #(.STABLE_CYCLES(8), .CNT_W(26)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    key_debouncer #(.STABLE_CYCLES(1), .CNT_W(2)) dut1 (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .key_raw     (key_raw1),
        .key_level   (key_level1),
        .key_press   (key_press1),
        .key_release (key_release1)
    );

    // Strobe bookkeeping plus exclusivity / no-back-to-back tracking for both instances.
    always @(negedge CLOCK_50) begin
        if (key_press) press_cnt++;
        if (key_release) release_cnt++;
        if (key_press1) press_cnt1++;
        if (key_release1) release_cnt1++;
        if (key_press && key_release) viol++;
        if (key_press1 && key_release1) viol++;
        if ((key_press || key_release) && prev_strobe) viol++;
        if ((key_press1 || key_release1) && prev_strobe1) viol++;
        prev_strobe  = key_press | key_release;
        prev_strobe1 = key_press1 | key_release1;
    end

    typedef struct {
        bit pressed;
        int hold;
        bit level;
        bit press;
        bit release_s;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive(input bit pressed);
        key_raw = pressed ^ ActLow;
    endtask

    task automatic drive1(input bit pressed);
        key_raw1 = pressed ^ ActLow;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // Bounce then release; each row: pressed, cycles held, then level/press/release expected.
        vecs[0] = '{1'b1, 3, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 3, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 3, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 10, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 9, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 10, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1, 1'b0, 1'b0, 1'b1};

        repeat (3) tick();
        chk("reset_level", key_level, 0);
        chk("reset_press", key_press, 0);
        chk("reset_release", key_release, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("idle_level", key_level, 0);

        // Clean press
        base_p = press_cnt;
        base_r = release_cnt;
        drive(1'b1);
        repeat (10) tick();
        chk("press_not_early", key_level, 0);
        tick();
        chk("press_level", key_level, 1);
        chk("press_strobe", key_press, 1);
        chk("press_no_release", key_release, 0);
        tick();
        chk("press_width", key_press, 0);
        repeat (8) tick();
        chk("press_held", key_level, 1);

        // Clean release
        drive(1'b0);
        repeat (10) tick();
        chk("release_not_early", key_level, 1);
        tick();
        chk("release_level", key_level, 0);
        chk("release_strobe", key_release, 1);
        chk("release_no_press", key_press, 0);
        tick();
        chk("release_width", key_release, 0);
        repeat (8) tick();
        chk("clean_press_count", press_cnt - base_p, 1);
        chk("clean_release_count", release_cnt - base_r, 1);

        // Bounce table
        base_p = press_cnt;
        base_r = release_cnt;
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].pressed);
            repeat (vecs[i].hold) tick();
            chk($sformatf("vec%0d_level", i), key_level, vecs[i].level);
            chk($sformatf("vec%0d_press", i), key_press, vecs[i].press);
            chk($sformatf("vec%0d_release", i), key_release, vecs[i].release_s);
        end
        tick();
        chk("bounce_press_count", press_cnt - base_p, 1);
        chk("bounce_release_count", release_cnt - base_r, 1);

        // Asynchronous reset while pressed clears level without a strobe
        base_r = release_cnt;
        drive(1'b1);
        repeat (12) tick();
        chk("pre_reset_level", key_level, 1);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_level", key_level, 0);
        tick();
        drive(1'b0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();

        // Reset five cycles into WAIT_HIGH, key held across deassertion
        base_p = press_cnt;
        drive(1'b1);
        repeat (7) tick();
        chk("wait_level", key_level, 0);
        #3 reset = 1'b1;
        #1;
        chk("midwait_reset_level", key_level, 0);
        chk("midwait_reset_press", key_press, 0);
        repeat (3) tick();
        chk("midwait_no_press", press_cnt - base_p, 0);
        reset = 1'b0;
        repeat (10) tick();
        chk("after_reset_not_early", key_level, 0);
        tick();
        chk("after_reset_level", key_level, 1);
        chk("after_reset_press", key_press, 1);
        tick();
        chk("after_reset_press_count", press_cnt - base_p, 1);
        chk("reset_no_release", release_cnt - base_r, 0);

        // STABLE_CYCLES = 1: one-sample glitch rejected, two-sample glitch accepted
        base_p1 = press_cnt1;
        drive1(1'b1);
        tick();
        drive1(1'b0);
        repeat (10) tick();
        chk("min_glitch1_level", key_level1, 0);
        chk("min_glitch1_count", press_cnt1 - base_p1, 0);
        drive1(1'b1);
        repeat (2) tick();
        drive1(1'b0);
        tick();
        chk("min_glitch2_not_early", key_level1, 0);
        tick();
        chk("min_glitch2_level", key_level1, 1);
        chk("min_glitch2_press", key_press1, 1);
        repeat (10) tick();
        chk("min_glitch2_count", press_cnt1 - base_p1, 1);
        chk("min_glitch2_released", key_level1, 0);

        chk("strobe_rules", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
